// File: rtl/trap_controller.sv
// Trap sequencer: arbitrates exceptions vs. enabled interrupts, drains/flushes, strobes the trap commit, redirects fetch.
// Latency: exc_valid/irq -> exception_pending in 2..DRAIN_MAX+1 cycles; redirect_valid follows exception_pending by 1 cycle.
// Backpressure: redirect_valid/redirect_pc hold until redirect_ready; new traps are ignored while busy.
module trap_controller #(
   parameter int XLEN      = 32,
   parameter int DRAIN_MAX = 15
) (
   input  logic            clk,
   input  logic            nrst,
   input  logic            exc_valid,
   input  logic [4:0]      exc_cause,
   input  logic [XLEN-1:0] exc_pc,
   input  logic [XLEN-1:0] irq_pc,
   input  logic            m_ext_ip,
   input  logic            m_tim_ip,
   input  logic            s_ext_ip,
   input  logic            s_tim_ip,
   input  logic            m_eie,
   input  logic            m_tie,
   input  logic            s_eie,
   input  logic            s_tie,
   input  logic            pipe_empty,
   input  logic [XLEN-1:0] mtvec_in,
   input  logic            redirect_ready,
   output logic            flush,
   output logic            exception_pending,
   output logic [XLEN-1:0] m_cause,
   output logic [XLEN-1:0] pc_exc,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            busy
);

   localparam int CW = $clog2(DRAIN_MAX + 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DRAIN    = 2'd1,
      TRAP     = 2'd2,
      REDIRECT = 2'd3
   } state_t;

   state_t        state;
   logic [CW-1:0] drain_cnt;
   logic [CW-1:0] drain_nxt;
   logic          drain_done;
   logic          irq_any;
   logic [4:0]    irq_code;

   // Count reaching DRAIN_MAX on this cycle forces trap entry even if the pipe never empties.
   assign drain_nxt  = drain_cnt + CW'(1);
   assign drain_done = pipe_empty || (drain_nxt == CW'(DRAIN_MAX));

   // Fixed-priority pick among taken interrupts: MEI > MTI > SEI > STI.
   always_comb begin
      irq_any  = 1'b0;
      irq_code = 5'd0;
      if (m_ext_ip && m_eie) begin
         irq_any  = 1'b1;
         irq_code = 5'd11;
      end else if (m_tim_ip && m_tie) begin
         irq_any  = 1'b1;
         irq_code = 5'd7;
      end else if (s_ext_ip && s_eie) begin
         irq_any  = 1'b1;
         irq_code = 5'd9;
      end else if (s_tim_ip && s_tie) begin
         irq_any  = 1'b1;
         irq_code = 5'd5;
      end
   end

   // Trap FSM; every output is registered alongside the state it belongs to.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state             <= IDLE;
         drain_cnt         <= '0;
         flush             <= 1'b0;
         exception_pending <= 1'b0;
         redirect_valid    <= 1'b0;
         busy              <= 1'b0;
         m_cause           <= '0;
         pc_exc            <= '0;
         redirect_pc       <= '0;
      end else begin
         case (state)
            IDLE: begin
               drain_cnt <= '0;
               // Exception wins over any interrupt seen in the same cycle.
               if (exc_valid) begin
                  m_cause <= {1'b0, {(XLEN-6){1'b0}}, exc_cause};
                  pc_exc  <= exc_pc;
                  flush   <= 1'b1;
                  busy    <= 1'b1;
                  state   <= DRAIN;
               end else if (irq_any) begin
                  m_cause <= {1'b1, {(XLEN-6){1'b0}}, irq_code};
                  pc_exc  <= irq_pc;
                  flush   <= 1'b1;
                  busy    <= 1'b1;
                  state   <= DRAIN;
               end
            end
            DRAIN: begin
               drain_cnt <= drain_nxt;
               if (drain_done) begin
                  exception_pending <= 1'b1;
                  state             <= TRAP;
               end
            end
            TRAP: begin
               exception_pending <= 1'b0;
               flush             <= 1'b0;
               drain_cnt         <= '0;
               redirect_pc       <= mtvec_in;
               redirect_valid    <= 1'b1;
               state             <= REDIRECT;
            end
            REDIRECT: begin
               if (redirect_ready) begin
                  redirect_valid <= 1'b0;
                  busy           <= 1'b0;
                  state          <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: reset, arbitration, drain timeout, redirect backpressure, mid-trap reset.
module tb_trap_controller;

   logic        clk = 1'b0;
   logic        nrst;
   logic        exc_valid;
   logic [4:0]  exc_cause;
   logic [31:0] exc_pc, irq_pc;
   logic        m_ext_ip, m_tim_ip, s_ext_ip, s_tim_ip;
   logic        m_eie, m_tie, s_eie, s_tie;
   logic        pipe_empty;
   logic [31:0] mtvec_in;
   logic        redirect_ready;
   logic        flush, exception_pending, redirect_valid, busy;
   logic [31:0] m_cause, pc_exc, redirect_pc;

   int n_tot = 0;
   int n_bad = 0;

   trap_controller #(.XLEN(32), .DRAIN_MAX(15)) dut (
      .clk(clk), .nrst(nrst),
      .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .irq_pc(irq_pc),
      .m_ext_ip(m_ext_ip), .m_tim_ip(m_tim_ip), .s_ext_ip(s_ext_ip), .s_tim_ip(s_tim_ip),
      .m_eie(m_eie), .m_tie(m_tie), .s_eie(s_eie), .s_tie(s_tie),
      .pipe_empty(pipe_empty), .mtvec_in(mtvec_in), .redirect_ready(redirect_ready),
      .flush(flush), .exception_pending(exception_pending),
      .m_cause(m_cause), .pc_exc(pc_exc),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic saw_pend;
      nrst = 1'b0; exc_valid = 1'b0; exc_cause = 5'd0; exc_pc = '0; irq_pc = '0;
      m_ext_ip = 1'b0; m_tim_ip = 1'b0; s_ext_ip = 1'b0; s_tim_ip = 1'b0;
      m_eie = 1'b0; m_tie = 1'b0; s_eie = 1'b0; s_tie = 1'b0;
      pipe_empty = 1'b1; mtvec_in = 32'h80; redirect_ready = 1'b0;
      tick; tick;
      chk("rst_flush", 32'(flush), 32'h0);
      chk("rst_pend",  32'(exception_pending), 32'h0);
      chk("rst_rv",    32'(redirect_valid), 32'h0);
      chk("rst_busy",  32'(busy), 32'h0);
      chk("rst_cause", m_cause, 32'h0);
      chk("rst_pc",    pc_exc, 32'h0);
      chk("rst_rpc",   redirect_pc, 32'h0);
      nrst = 1'b1;
      tick;

      // 1: basic exception, pipe already empty
      exc_valid = 1'b1; exc_cause = 5'd2; exc_pc = 32'h100;
      tick;
      exc_valid = 1'b0;
      chk("t1_drain_flush", 32'(flush), 32'h1);
      chk("t1_drain_pend",  32'(exception_pending), 32'h0);
      chk("t1_drain_busy",  32'(busy), 32'h1);
      tick;
      chk("t1_pend",  32'(exception_pending), 32'h1);
      chk("t1_flush", 32'(flush), 32'h1);
      chk("t1_cause", m_cause, 32'h2);
      chk("t1_pc",    pc_exc, 32'h100);
      tick;
      chk("t1_pend_off", 32'(exception_pending), 32'h0);
      chk("t1_flush_off", 32'(flush), 32'h0);
      chk("t1_rv",  32'(redirect_valid), 32'h1);
      chk("t1_rpc", redirect_pc, 32'h80);
      redirect_ready = 1'b1;
      tick;
      chk("t1_rv_off", 32'(redirect_valid), 32'h0);
      chk("t1_idle",   32'(busy), 32'h0);

      // 2: MTI beats SEI; SEI taken after return
      m_tim_ip = 1'b1; m_tie = 1'b1; s_ext_ip = 1'b1; s_eie = 1'b1; irq_pc = 32'h200;
      tick;
      m_tim_ip = 1'b0;
      chk("t2_cause", m_cause, 32'h80000007);
      chk("t2_pc",    pc_exc, 32'h200);
      tick;
      chk("t2_pend",  32'(exception_pending), 32'h1);
      chk("t2_cause_hold", m_cause, 32'h80000007);
      tick;
      chk("t2_rv", 32'(redirect_valid), 32'h1);
      tick;
      chk("t2_idle", 32'(busy), 32'h0);
      tick;
      s_ext_ip = 1'b0;
      chk("t2_sei_cause", m_cause, 32'h80000009);
      chk("t2_sei_busy",  32'(busy), 32'h1);
      tick; tick; tick;
      chk("t2_sei_done", 32'(busy), 32'h0);

      // 3: exception beats MEI in the same cycle; MEI follows
      exc_valid = 1'b1; exc_cause = 5'd11; exc_pc = 32'h300;
      m_ext_ip = 1'b1; m_eie = 1'b1; irq_pc = 32'h400; redirect_ready = 1'b0;
      tick;
      exc_valid = 1'b0;
      chk("t3_cause", m_cause, 32'h0000000B);
      chk("t3_pc",    pc_exc, 32'h300);
      tick; tick;
      chk("t3_rv", 32'(redirect_valid), 32'h1);
      tick;
      chk("t3_rv_hold", 32'(redirect_valid), 32'h1);
      redirect_ready = 1'b1;
      tick;
      chk("t3_idle", 32'(busy), 32'h0);
      tick;
      m_ext_ip = 1'b0;
      chk("t3_mei_cause", m_cause, 32'h8000000B);
      chk("t3_mei_pc",    pc_exc, 32'h400);
      tick; tick; tick;
      chk("t3_mei_done", 32'(busy), 32'h0);

      // 4a: pipe never empties -> forced entry DRAIN_MAX+1 cycles after exc_valid
      pipe_empty = 1'b0; exc_valid = 1'b1; exc_cause = 5'd4; exc_pc = 32'h500;
      n = 0;
      do begin
         tick; n++;
         exc_valid = 1'b0;
      end while (!exception_pending && n < 40);
      chk("t4_timeout_lat", 32'(n), 32'd16);
      chk("t4_flush", 32'(flush), 32'h1);
      tick; tick;
      chk("t4_idle", 32'(busy), 32'h0);
      // 4b: pipe empties during drain cycle 3 -> trap next cycle
      exc_valid = 1'b1;
      n = 0;
      do begin
         tick; n++;
         exc_valid = 1'b0;
         if (n == 3) pipe_empty = 1'b1;
      end while (!exception_pending && n < 40);
      chk("t4_empty_lat", 32'(n), 32'd4);
      tick; tick;
      chk("t4b_idle", 32'(busy), 32'h0);

      // 5: redirect held under backpressure; second exception ignored
      exc_valid = 1'b1; exc_cause = 5'd5; exc_pc = 32'h600; mtvec_in = 32'h1000;
      redirect_ready = 1'b0;
      tick;
      exc_valid = 1'b0;
      tick; tick;
      mtvec_in = 32'hDEAD;
      exc_valid = 1'b1; exc_cause = 5'd7; exc_pc = 32'h700;
      for (int i = 0; i < 5; i++) begin
         chk("t5_rv",   32'(redirect_valid), 32'h1);
         chk("t5_rpc",  redirect_pc, 32'h1000);
         chk("t5_busy", 32'(busy), 32'h1);
         chk("t5_pend", 32'(exception_pending), 32'h0);
         tick;
      end
      exc_valid = 1'b0;
      redirect_ready = 1'b1;
      chk("t5_rv_last", 32'(redirect_valid), 32'h1);
      tick;
      chk("t5_idle",  32'(busy), 32'h0);
      chk("t5_cause", m_cause, 32'h5);
      chk("t5_pc",    pc_exc, 32'h600);

      // 6: reset during DRAIN aborts the trap
      mtvec_in = 32'h2000;
      pipe_empty = 1'b0; exc_valid = 1'b1; exc_cause = 5'd3; exc_pc = 32'h800;
      tick;
      exc_valid = 1'b0;
      tick;
      chk("t6_in_drain", 32'(flush), 32'h1);
      #2 nrst = 1'b0;
      #1;
      chk("t6_flush", 32'(flush), 32'h0);
      chk("t6_busy",  32'(busy), 32'h0);
      chk("t6_cause", m_cause, 32'h0);
      chk("t6_pc",    pc_exc, 32'h0);
      chk("t6_rv",    32'(redirect_valid), 32'h0);
      saw_pend = 1'b0;
      tick; tick;
      nrst = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (exception_pending) saw_pend = 1'b1;
         tick;
      end
      chk("t6_no_pend", 32'(saw_pend), 32'h0);
      chk("t6_idle", 32'(busy), 32'h0);
      pipe_empty = 1'b1; exc_valid = 1'b1; exc_cause = 5'd1; exc_pc = 32'h900;
      tick;
      exc_valid = 1'b0;
      chk("t6_new_cause", m_cause, 32'h1);
      tick;
      chk("t6_new_pend", 32'(exception_pending), 32'h1);
      tick;
      chk("t6_new_rpc", redirect_pc, 32'h2000);
      tick;
      chk("t6_new_idle", 32'(busy), 32'h0);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
